tempo_pulse_gen: RTL
====================

# tempo_pulse_gen

Multi-channel programmable tempo generator for the synth's song sequencer. Each channel emits a one-cycle beat strobe every PERIOD clocks, a stretched pulse of HIGH clocks at the start of each period, and a wrapping beat index with a measure strobe. It supersedes the single fixed-rate pulse source: per-channel enables, run-time period and width, one-shot mode and a global phase restart.

## Interface
- CHANNELS, 4, number of independent pulse channels (1..8)
- CNT_W, 28, period counter width
- HIGH_W, 8, pulse-width field width
- BEAT_W, 2, beat index width; beats per measure = 2**BEAT_W
- DEFAULT_PERIOD, 9000000, period loaded at reset
- DEFAULT_HIGH, 31, pulse width loaded at reset
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  CHANNELS  per-channel run enable, level sensitive
- oneshot  in  CHANNELS  per-channel mode: 0 periodic, 1 single period then stop
- restart  in  1  one-cycle global phase restart of all running channels
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  clog2(CHANNELS) (min 1)  target channel of write
- cfg_period  in  CNT_W  new period in clocks
- cfg_high  in  HIGH_W  new pulse width in clocks
- strobe  out  CHANNELS  one-cycle beat strobe per period
- pulse  out  CHANNELS  stretched pulse, high for HIGH clocks from strobe
- beat_idx  out  CHANNELS*BEAT_W  current beat per channel, channel c at [c*BEAT_W +: BEAT_W]
- measure  out  CHANNELS  one-cycle strobe coincident with strobe when beat_idx wraps to 0
- busy  out  CHANNELS  channel in RUN state

## Operation
- Per-channel FSM: IDLE, RUN, DONE.
- IDLE: cnt=0, beat=0, all outputs 0. enable=1 → RUN; first strobe, pulse, measure asserted in the first RUN cycle, cnt=0.
- RUN: cnt increments each clock; at cnt==period-1, cnt←0, strobe=1, beat←beat+1 (mod 2**BEAT_W); measure=1 when new beat==0. pulse=1 while cnt<high.
- oneshot=1 (sampled at each boundary): at cnt==period-1 go DONE instead of wrapping; no further strobe.
- DONE: outputs 0; stays until enable=0, then IDLE. Re-trigger requires enable low for ≥1 clock.
- enable=0 in any state → IDLE next edge, overrides everything.
- restart=1: every channel in RUN gets cnt←0, beat←0, and strobe+measure+pulse in the following cycle; IDLE/DONE channels unaffected.
- Config: cfg_we writes shadow regs of cfg_ch. Active regs load from shadow at every period boundary (cnt==period-1), on restart, and continuously while IDLE/DONE. No mid-period change.
- Clamping on load: period<2 → 2; high≥period → period-1. high=0 → pulse never asserted, strobe still produced.
- Simultaneous cfg_we and boundary on same channel: new value used for the next period.
- cfg_ch ≥ CHANNELS: write ignored.

## Timing
- Reset values: strobe, pulse, measure, busy = 0; beat_idx = 0; period = DEFAULT_PERIOD; high = DEFAULT_HIGH; all FSMs IDLE.
- Enable latency: enable high sampled at edge k → strobe/pulse high in cycle after edge k+1 (one registered stage).
- Strobe spacing exactly period clocks; pulse high exactly min(high, period-1) clocks beginning with strobe cycle.
- restart sampled at edge k → strobe in cycle after edge k+1 (one registered stage).
- All outputs registered; no combinational input-to-output path.
- Reset asserted mid-operation: outputs clear asynchronously; config reverts to defaults.

## Structure
- Shared package tempo_pkg: FSM state enum (IDLE, RUN, DONE), MIN_PERIOD=2, default constants.
- Sub-module tempo_pulse_channel: one FSM, counter, shadow/active regs, beat counter; top instantiates CHANNELS copies, decodes cfg_ch, fans out restart, packs beat_idx.

## Test plan
- Reset then enable[0]=1, cfg period=10 high=3: strobe[0] every 10 clocks, pulse[0] 3 clocks each, beat_idx 0,1,2,3,0 with measure on the wrap.
- Write period=1 high=5 to ch1, enable: period clamps to 2, high to 1; strobe every 2 clocks, pulse 1 clock.
- oneshot[2]=1, period=6: exactly one strobe, busy high 6 clocks, then DONE; second strobe only after enable low for 1 clock then high.
- Ch0 and ch1 period=8, enabled 3 clocks apart, pulse restart: both strobe in the same cycle afterwards, beat_idx both 0.
- Mid-period cfg write period=20 to running ch3 (period=10): current period completes at 10, next strobe gap 20.
- enable dropped and reset_n pulsed mid-pulse: outputs 0 next edge / immediately; after reset, period reads back DEFAULT_PERIOD spacing.

Source files
------------

// File: rtl/tempo_pkg.sv
// Shared types and constants for the multi-channel tempo pulse generator.
package tempo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tempo_state_e;

    localparam int unsigned MIN_PERIOD = 2;
    localparam int unsigned DEF_PERIOD = 9000000;
    localparam int unsigned DEF_HIGH   = 31;

endpackage

// File: rtl/tempo_pulse_channel.sv
// One tempo channel: run/one-shot FSM, period counter, beat counter and
// shadow/active configuration registers. All outputs are registered.
module tempo_pulse_channel
    import tempo_pkg::*;
#(
    parameter int          CNT_W          = 28,
    parameter int          HIGH_W         = 8,
    parameter int          BEAT_W         = 2,
    parameter int unsigned DEFAULT_PERIOD = DEF_PERIOD,
    parameter int unsigned DEFAULT_HIGH   = DEF_HIGH
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_oneshot,
    input  logic              i_restart,
    input  logic              i_cfg_we,
    input  logic [CNT_W-1:0]  i_cfg_period,
    input  logic [HIGH_W-1:0] i_cfg_high,
    output logic              o_strobe,
    output logic              o_pulse,
    output logic              o_measure,
    output logic              o_busy,
    output logic [BEAT_W-1:0] o_beat_idx
);

    localparam logic [CNT_W-1:0]  RST_PERIOD = CNT_W'(DEFAULT_PERIOD);
    localparam logic [HIGH_W-1:0] RST_HIGH   = HIGH_W'(DEFAULT_HIGH);

    function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
        return (p < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : p;
    endfunction

    // The pulse must end before the next strobe, so width is capped at period-1.
    function automatic logic [HIGH_W-1:0] clamp_high(input logic [HIGH_W-1:0] h,
                                                     input logic [CNT_W-1:0]  p);
        logic [CNT_W-1:0] pm1;
        pm1 = p - 1'b1;
        return (CNT_W'(h) >= p) ? pm1[HIGH_W-1:0] : h;
    endfunction

    tempo_state_e      r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_period;
    logic [CNT_W-1:0]  r_shd_period;
    logic [HIGH_W-1:0] r_high;
    logic [HIGH_W-1:0] r_shd_high;
    logic [BEAT_W-1:0] r_beat;
    logic              r_strobe;
    logic              r_pulse;
    logic              r_measure;
    logic              r_busy;
    logic [BEAT_W-1:0] r_beat_o;

    logic              w_run;
    logic              w_active;
    logic              w_boundary;
    logic              w_load;
    logic [CNT_W-1:0]  w_new_period;
    logic [HIGH_W-1:0] w_new_high;

    assign w_run        = (r_state == ST_RUN);
    assign w_active     = w_run && i_enable;
    assign w_boundary   = w_run && (r_cnt == r_period - 1'b1);
    assign w_load       = !w_run || w_boundary || i_restart;
    // A write landing on the load edge bypasses the shadow so it applies to the next period.
    assign w_new_period = clamp_period(i_cfg_we ? i_cfg_period : r_shd_period);
    assign w_new_high   = clamp_high(i_cfg_we ? i_cfg_high : r_shd_high, w_new_period);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_beat       <= '0;
            r_period     <= RST_PERIOD;
            r_high       <= RST_HIGH;
            r_shd_period <= RST_PERIOD;
            r_shd_high   <= RST_HIGH;
            r_strobe     <= 1'b0;
            r_pulse      <= 1'b0;
            r_measure    <= 1'b0;
            r_busy       <= 1'b0;
            r_beat_o     <= '0;
        end else begin
            if (i_cfg_we) begin
                r_shd_period <= i_cfg_period;
                r_shd_high   <= i_cfg_high;
            end
            if (w_load) begin
                r_period <= w_new_period;
                r_high   <= w_new_high;
            end

            if (!i_enable) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_beat  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                        r_beat  <= '0;
                    end
                    ST_RUN: begin
                        if (i_restart) begin
                            r_cnt  <= '0;
                            r_beat <= '0;
                        end else if (w_boundary) begin
                            r_cnt <= '0;
                            if (i_oneshot) begin
                                r_state <= ST_DONE;
                                r_beat  <= '0;
                            end else begin
                                r_beat <= r_beat + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_DONE: r_state <= ST_DONE;
                    default: r_state <= ST_IDLE;
                endcase
            end

            // Outputs trail the counter by one stage; dropping enable clears them at once.
            r_strobe  <= w_active && (r_cnt == '0);
            r_pulse   <= w_active && (r_cnt < CNT_W'(r_high));
            r_measure <= w_active && (r_cnt == '0) && (r_beat == '0);
            r_busy    <= w_active;
            r_beat_o  <= w_active ? r_beat : '0;
        end
    end

    assign o_strobe   = r_strobe;
    assign o_pulse    = r_pulse;
    assign o_measure  = r_measure;
    assign o_busy     = r_busy;
    assign o_beat_idx = r_beat_o;

endmodule

// File: rtl/tempo_pulse_gen.sv
// Multi-channel tempo generator: decodes configuration writes, fans out the
// global restart and packs per-channel beat indices.
module tempo_pulse_gen
    import tempo_pkg::*;
#(
    parameter int          CHANNELS       = 4,
    parameter int          CNT_W          = 28,
    parameter int          HIGH_W         = 8,
    parameter int          BEAT_W         = 2,
    parameter int unsigned DEFAULT_PERIOD = DEF_PERIOD,
    parameter int unsigned DEFAULT_HIGH   = DEF_HIGH
) (
    input  logic                                           clock,
    input  logic                                           reset_n,
    input  logic [CHANNELS-1:0]                            enable,
    input  logic [CHANNELS-1:0]                            oneshot,
    input  logic                                           restart,
    input  logic                                           cfg_we,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                               cfg_period,
    input  logic [HIGH_W-1:0]                              cfg_high,
    output logic [CHANNELS-1:0]                            strobe,
    output logic [CHANNELS-1:0]                            pulse,
    output logic [CHANNELS*BEAT_W-1:0]                     beat_idx,
    output logic [CHANNELS-1:0]                            measure,
    output logic [CHANNELS-1:0]                            busy
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] w_cfg_sel;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        // Out-of-range channel numbers match no instance and are dropped.
        assign w_cfg_sel[c] = cfg_we && (cfg_ch == CH_W'(c));

        tempo_pulse_channel #(
            .CNT_W          (CNT_W),
            .HIGH_W         (HIGH_W),
            .BEAT_W         (BEAT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD),
            .DEFAULT_HIGH   (DEFAULT_HIGH)
        ) u_ch (
            .i_clk        (clock),
            .i_rst_n      (reset_n),
            .i_enable     (enable[c]),
            .i_oneshot    (oneshot[c]),
            .i_restart    (restart),
            .i_cfg_we     (w_cfg_sel[c]),
            .i_cfg_period (cfg_period),
            .i_cfg_high   (cfg_high),
            .o_strobe     (strobe[c]),
            .o_pulse      (pulse[c]),
            .o_measure    (measure[c]),
            .o_busy       (busy[c]),
            .o_beat_idx   (beat_idx[c*BEAT_W +: BEAT_W])
        );
    end

endmodule
